plugin_sequencer: RTL and testbench

Issue sequencer between the RS5 execute stage and the hardware plugin bank (Fibonacci, ADD and future accelerators using the start/busy/done/result plugin contract). It accepts one custom-instruction request at a time, latches the operands, issues a single start pulse to the selected plugin, and waits for its done pulse or a timeout. It then returns the result to writeback through a valid/ready handshake, stalling the pipeline for the whole transaction.

---
 rtl/RS5_pkg.sv | 18 +
 rtl/plugin_sequencer_result_mux.sv | 32 +++
 rtl/plugin_sequencer.sv | 162 ++++++++++++++++
 tb/tb_plugin_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/RS5_pkg.sv
// Shared RS5 definitions used by the plugin issue sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: sequencer state encoding and the data word returned on a plugin timeout.
package RS5_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } plg_seq_state_t;

   // Returned in wb_data when the selected plugin never signals done.
   localparam logic [31:0] PLG_TIMEOUT_DATA = 32'hFFFF_FFFF;

endpackage

// File: rtl/plugin_sequencer_result_mux.sv
// Selects the result word and done bit of one plugin from the packed plugin bank.
// Latency: combinational, zero cycles.
// Backpressure: none; pure select.
//
// Ports: sel (plugin index), plg_result (packed 32-bit results, plugin i at [32i+31:32i]),
//        plg_done (per-plugin done pulses) -> result / done of the selected plugin.
//        An out-of-range sel yields result=0 and done=0.
module plugin_result_mux
   import RS5_pkg::*;
#(
   parameter int NUM_PLUGINS = 4,
   parameter int SEL_W       = 2
) (
   input  logic [SEL_W-1:0]          sel,
   input  logic [NUM_PLUGINS*32-1:0] plg_result,
   input  logic [NUM_PLUGINS-1:0]    plg_done,
   output logic [31:0]               result,
   output logic                      done
);

   always_comb begin
      result = '0;
      done   = 1'b0;
      for (int i = 0; i < NUM_PLUGINS; i++) begin
         if (32'(sel) == i) begin
            result = plg_result[32*i +: 32];
            done   = plg_done[i];
         end
      end
   end

endmodule

// File: rtl/plugin_sequencer.sv
// Issues one custom-instruction request to a plugin and returns its result to writeback.
// Latency: >=3 cycles acceptance->wb_valid for a valid plugin, 1 cycle for an invalid select.
// Backpressure: req_ready only in IDLE; the response holds on wb_* until wb_ready.
//
// Ports: clk/reset (sync, active-high); req_* request from execute (valid/ready);
//        stall holds the pipeline while busy; plg_start/plg_operand_* drive the plugin bank;
//        plg_busy/plg_done/plg_result come back from it; wb_* is the writeback response.
module plugin_sequencer
   import RS5_pkg::*;
#(
   parameter int NUM_PLUGINS    = 4,
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int SEL_W          = (NUM_PLUGINS > 1) ? $clog2(NUM_PLUGINS) : 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic [SEL_W-1:0]          req_sel,
   input  logic [4:0]                req_rd,
   input  logic [31:0]               req_op_a,
   input  logic [31:0]               req_op_b,
   output logic                      stall,
   output logic [NUM_PLUGINS-1:0]    plg_start,
   output logic [31:0]               plg_operand_a,
   output logic [31:0]               plg_operand_b,
   input  logic [NUM_PLUGINS-1:0]    plg_busy,
   input  logic [NUM_PLUGINS-1:0]    plg_done,
   input  logic [NUM_PLUGINS*32-1:0] plg_result,
   output logic                      wb_valid,
   input  logic                      wb_ready,
   output logic [4:0]                wb_rd,
   output logic [31:0]               wb_data,
   output logic                      wb_error
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

   plg_seq_state_t          state_q, state_d;
   logic [SEL_W-1:0]        sel_q, sel_d;
   logic [4:0]              rd_q, rd_d;
   logic [31:0]             op_a_q, op_a_d;
   logic [31:0]             op_b_q, op_b_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [NUM_PLUGINS-1:0]  start_q, start_d;
   logic [31:0]             wb_data_q, wb_data_d;
   logic [4:0]              wb_rd_q, wb_rd_d;
   logic                    wb_error_q, wb_error_d;

   logic [31:0]             sel_result;
   logic                    sel_done;

   // Busy flags are for debug visibility only; nothing here depends on them.
   logic                    plg_busy_unused;
   assign plg_busy_unused = ^plg_busy;

   plugin_result_mux #(
      .NUM_PLUGINS (NUM_PLUGINS),
      .SEL_W       (SEL_W)
   ) u_result_mux (
      .sel        (sel_q),
      .plg_result (plg_result),
      .plg_done   (plg_done),
      .result     (sel_result),
      .done       (sel_done)
   );

   always_comb begin
      state_d    = state_q;
      sel_d      = sel_q;
      rd_d       = rd_q;
      op_a_d     = op_a_q;
      op_b_d     = op_b_q;
      cnt_d      = cnt_q;
      start_d    = '0;
      wb_data_d  = wb_data_q;
      wb_rd_d    = wb_rd_q;
      wb_error_d = wb_error_q;

      unique case (state_q)
         IDLE: begin
            if (req_valid) begin
               sel_d  = req_sel;
               rd_d   = req_rd;
               op_a_d = req_op_a;
               op_b_d = req_op_b;
               cnt_d  = '0;
               if (32'(req_sel) < NUM_PLUGINS) begin
                  state_d = START;
                  // Start is registered so the pulse lands exactly in the START cycle.
                  for (int i = 0; i < NUM_PLUGINS; i++) begin
                     start_d[i] = (32'(req_sel) == i);
                  end
               end else begin
                  state_d    = RESP;
                  wb_data_d  = '0;
                  wb_rd_d    = req_rd;
                  wb_error_d = 1'b1;
               end
            end
         end
         // A done seen while in START belongs to an older transaction and is ignored.
         START: state_d = WAIT;
         WAIT: begin
            cnt_d = cnt_q + CNT_W'(1);
            // Done takes priority over a timeout landing in the same cycle.
            if (sel_done) begin
               state_d    = RESP;
               wb_data_d  = sel_result;
               wb_rd_d    = rd_q;
               wb_error_d = 1'b0;
            end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               state_d    = RESP;
               wb_data_d  = PLG_TIMEOUT_DATA;
               wb_rd_d    = rd_q;
               wb_error_d = 1'b1;
            end
         end
         RESP: begin
            if (wb_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         sel_q      <= '0;
         rd_q       <= '0;
         op_a_q     <= '0;
         op_b_q     <= '0;
         cnt_q      <= '0;
         start_q    <= '0;
         wb_data_q  <= '0;
         wb_rd_q    <= '0;
         wb_error_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         sel_q      <= sel_d;
         rd_q       <= rd_d;
         op_a_q     <= op_a_d;
         op_b_q     <= op_b_d;
         cnt_q      <= cnt_d;
         start_q    <= start_d;
         wb_data_q  <= wb_data_d;
         wb_rd_q    <= wb_rd_d;
         wb_error_q <= wb_error_d;
      end
   end

   assign req_ready     = (state_q == IDLE);
   assign stall         = (state_q != IDLE);
   assign wb_valid      = (state_q == RESP);
   assign plg_start     = start_q;
   assign plg_operand_a = op_a_q;
   assign plg_operand_b = op_b_q;
   assign wb_data       = wb_data_q;
   assign wb_rd         = wb_rd_q;
   assign wb_error      = wb_error_q;

endmodule

// File: tb/tb_plugin_sequencer.sv
// Self-checking bench for plugin_sequencer with three modelled plugins:
// 0 = Fibonacci, 1 = adder with programmable delay, 2 = xor with programmable delay.
// Directed table, reset-during-WAIT sequence, then randomized transactions against a reference model.
module tb_plugin_sequencer;

   localparam int N     = 3;
   localparam int T     = 16;
   localparam int NEVER = 100000;

   logic        clk;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_sel;
   logic [4:0]  req_rd;
   logic [31:0] req_op_a;
   logic [31:0] req_op_b;
   logic        stall;
   logic [2:0]  plg_start;
   logic [31:0] plg_operand_a;
   logic [31:0] plg_operand_b;
   logic [2:0]  plg_busy;
   logic [2:0]  plg_done;
   logic [95:0] plg_result;
   logic        wb_valid;
   logic        wb_ready;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        wb_error;

   int          checks;
   int          errors;
   int          cyc;
   int          done_at [3];
   logic [31:0] res [3];
   int          lat1;
   int          lat2;
   bit          tog2;

   plugin_sequencer #(
      .NUM_PLUGINS    (N),
      .TIMEOUT_CYCLES (T)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_sel       (req_sel),
      .req_rd        (req_rd),
      .req_op_a      (req_op_a),
      .req_op_b      (req_op_b),
      .stall         (stall),
      .plg_start     (plg_start),
      .plg_operand_a (plg_operand_a),
      .plg_operand_b (plg_operand_b),
      .plg_busy      (plg_busy),
      .plg_done      (plg_done),
      .plg_result    (plg_result),
      .wb_valid      (wb_valid),
      .wb_ready      (wb_ready),
      .wb_rd         (wb_rd),
      .wb_data       (wb_data),
      .wb_error      (wb_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- plugin models ----------------
   function automatic logic [31:0] fib(input logic [31:0] n);
      logic [31:0] x, y, t;
      x = 0; y = 1;
      for (int i = 0; i < int'(n); i++) begin
         t = x + y; x = y; y = t;
      end
      return x;
   endfunction

   // Cycles from the start pulse to the done pulse.
   function automatic int plugin_delay(input int p, input logic [31:0] a);
      if (p == 0) return (int'(a) + 2 < 3) ? 3 : int'(a) + 2;
      if (p == 1) return lat1;
      return lat2;
   endfunction

   function automatic logic [31:0] plugin_value(input int p, input logic [31:0] a, input logic [31:0] b);
      if (p == 0) return fib(a);
      if (p == 1) return a + b;
      return a ^ b;
   endfunction

   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (plg_start[i]) begin
            done_at[i] = cyc + plugin_delay(i, plg_operand_a);
            res[i]     = plugin_value(i, plg_operand_a, plg_operand_b);
         end
      end
   end

   always @(posedge clk) begin
      #1;
      for (int i = 0; i < 3; i++) begin
         plg_done[i] = (cyc == done_at[i]) || (i == 2 && tog2 && cyc[0]);
      end
   end

   assign plg_result = {res[2], res[1], res[0]};
   assign plg_busy   = '0;

   // ---------------- reference model ----------------
   task automatic model(input logic [1:0] sel, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] data, output logic err);
      int d;
      if (int'(sel) >= N) begin
         lat = 1; data = 0; err = 1'b1;
      end else begin
         d = plugin_delay(int'(sel), a);
         if (d <= T) begin
            lat = d + 2; data = plugin_value(int'(sel), a, b); err = 1'b0;
         end else begin
            lat = T + 2; data = 32'hFFFF_FFFF; err = 1'b1;
         end
      end
   endtask

   // ---------------- checking helpers ----------------
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic check_reset(input string nm);
      chk({nm, ".wb_valid"},  32'(wb_valid), 0);
      chk({nm, ".wb_data"},   wb_data, 0);
      chk({nm, ".wb_rd"},     32'(wb_rd), 0);
      chk({nm, ".wb_error"},  32'(wb_error), 0);
      chk({nm, ".plg_start"}, 32'(plg_start), 0);
      chk({nm, ".op_a"},      plg_operand_a, 0);
      chk({nm, ".op_b"},      plg_operand_b, 0);
      chk({nm, ".stall"},     32'(stall), 0);
      chk({nm, ".req_ready"}, 32'(req_ready), 1);
   endtask

   // Drives one request, follows it to the writeback handshake, checks timing and payload.
   task automatic run_txn(input string nm, input logic [1:0] sel, input logic [4:0] rd,
                          input logic [31:0] a, input logic [31:0] b, input int rdly,
                          input int exp_lat, input logic [31:0] exp_data, input logic exp_err);
      int          acc, got_lat, nstart, start_cyc;
      logic [2:0]  start_bits;
      logic [31:0] d0;
      logic [4:0]  r0;
      logic        e0;
      bit          stall_ok, stable_ok;
      req_valid = 1'b1; req_sel = sel; req_rd = rd; req_op_a = a; req_op_b = b; wb_ready = 1'b0;
      #1;
      chk({nm, ".req_ready"}, 32'(req_ready), 1);
      acc = cyc;
      @(posedge clk); #1;
      req_valid = 1'b0; req_op_a = $urandom; req_op_b = $urandom; req_rd = 5'h1f;
      got_lat = -1; nstart = 0; start_cyc = -1; start_bits = '0; stall_ok = 1;
      for (int k = 0; k < 300 && got_lat < 0; k++) begin
         @(negedge clk);
         if (plg_start != '0) begin
            nstart++; start_bits = plg_start; start_cyc = cyc - acc;
         end
         if (!stall) stall_ok = 0;
         if (wb_valid) got_lat = cyc - acc;
         else begin
            @(posedge clk); #1;
         end
      end
      chk({nm, ".latency"},  32'(got_lat), 32'(exp_lat));
      if (got_lat < 0) return;
      chk({nm, ".wb_data"},  wb_data, exp_data);
      chk({nm, ".wb_error"}, 32'(wb_error), 32'(exp_err));
      chk({nm, ".wb_rd"},    32'(wb_rd), 32'(rd));
      chk({nm, ".stall"},    32'(stall_ok), 1);
      chk({nm, ".op_a"},     plg_operand_a, a);
      chk({nm, ".op_b"},     plg_operand_b, b);
      chk({nm, ".req_ready_resp"}, 32'(req_ready), 0);
      if (int'(sel) < N) begin
         chk({nm, ".start_count"}, 32'(nstart), 1);
         chk({nm, ".start_bits"},  32'(start_bits), 32'(3'b001 << sel));
         chk({nm, ".start_cycle"}, 32'(start_cyc), 1);
      end else begin
         chk({nm, ".start_count"}, 32'(nstart), 0);
      end
      d0 = wb_data; r0 = wb_rd; e0 = wb_error; stable_ok = 1;
      repeat (rdly) begin
         @(posedge clk); #1;
         @(negedge clk);
         if (!wb_valid || wb_data !== d0 || wb_rd !== r0 || wb_error !== e0 || req_ready) stable_ok = 0;
      end
      if (rdly > 0) chk({nm, ".hold_stable"}, 32'(stable_ok), 1);
      @(posedge clk); #1; wb_ready = 1'b1;
      @(posedge clk); #1; wb_ready = 1'b0;
      @(negedge clk);
      chk({nm, ".after_hs"}, 32'({wb_valid, req_ready, stall}), 32'(3'b010));
   endtask

   // ---------------- directed vectors ----------------
   typedef struct {
      logic [1:0]  sel;
      logic [4:0]  rd;
      logic [31:0] a;
      logic [31:0] b;
      int          l1;
      int          l2;
      int          rdly;
      bit          tog;
      int          lat;
      logic [31:0] data;
      logic        err;
   } vec_t;

   vec_t vecs [9];

   initial begin
      int          m_lat;
      logic [31:0] m_data;
      logic        m_err;
      logic [1:0]  s;
      logic [31:0] a;
      bit          quiet_ok;

      checks = 0; errors = 0;
      for (int i = 0; i < 3; i++) begin done_at[i] = -1000; res[i] = '0; end
      reset = 1'b1; req_valid = 1'b0; req_sel = '0; req_rd = '0; req_op_a = '0; req_op_b = '0;
      wb_ready = 1'b0; tog2 = 1'b0; lat1 = 1; lat2 = NEVER;

      //        sel   rd     a             b             l1  l2     rdly tog lat data           err
      vecs[0] = '{2'd0, 5'd7,  32'd10,       32'd0,        1,  NEVER, 0,   0,  14, 32'd55,        1'b0};
      vecs[1] = '{2'd0, 5'd3,  32'd0,        32'd0,        1,  NEVER, 0,   0,  5,  32'd0,         1'b0};
      vecs[2] = '{2'd0, 5'd4,  32'd1,        32'd0,        1,  NEVER, 2,   0,  5,  32'd1,         1'b0};
      vecs[3] = '{2'd3, 5'd9,  32'd123,      32'd456,      1,  NEVER, 0,   0,  1,  32'd0,         1'b1};
      vecs[4] = '{2'd2, 5'd10, 32'd7,        32'd8,        1,  NEVER, 1,   0,  18, 32'hFFFF_FFFF, 1'b1};
      vecs[5] = '{2'd1, 5'd11, 32'd5,        32'd6,        16, NEVER, 0,   0,  18, 32'd11,        1'b0};
      vecs[6] = '{2'd1, 5'd12, 32'd5,        32'd6,        17, NEVER, 0,   0,  18, 32'hFFFF_FFFF, 1'b1};
      vecs[7] = '{2'd1, 5'd13, 32'd100,      32'd23,       1,  NEVER, 0,   0,  3,  32'd123,       1'b0};
      vecs[8] = '{2'd1, 5'd14, 32'h8000_0000, 32'h8000_0001, 4, NEVER, 5,   1,  6,  32'd1,         1'b0};

      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check_reset("por");

      for (int i = 0; i < 9; i++) begin
         lat1 = vecs[i].l1; lat2 = vecs[i].l2; tog2 = vecs[i].tog;
         run_txn($sformatf("vec%0d", i), vecs[i].sel, vecs[i].rd, vecs[i].a, vecs[i].b,
                 vecs[i].rdly, vecs[i].lat, vecs[i].data, vecs[i].err);
      end
      tog2 = 1'b0;

      // Reset while waiting on plugin 1; its late done must not produce a response.
      lat1 = 8;
      req_valid = 1'b1; req_sel = 2'd1; req_rd = 5'd21; req_op_a = 32'd3; req_op_b = 32'd4;
      @(posedge clk); #1 req_valid = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst_wait.stall_before", 32'(stall), 1);
      @(posedge clk); #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      check_reset("rst_wait");
      quiet_ok = 1;
      repeat (12) begin
         @(negedge clk);
         if (wb_valid || !req_ready || plg_start != '0) quiet_ok = 0;
      end
      chk("rst_wait.quiet_after", 32'(quiet_ok), 1);

      // Randomized transactions against the reference model.
      for (int i = 0; i < 40; i++) begin
         lat1 = $urandom_range(1, 20);
         lat2 = $urandom_range(1, 20);
         s = 2'($urandom_range(0, 3));
         a = (s == 2'd0) ? 32'($urandom_range(0, 18)) : $urandom;
         req_op_b = $urandom;
         model(s, a, req_op_b, m_lat, m_data, m_err);
         run_txn($sformatf("rnd%0d", i), s, 5'($urandom_range(0, 31)), a, req_op_b,
                 $urandom_range(0, 3), m_lat, m_data, m_err);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

endmodule
